// File: rtl/wfg_mem_arbiter.sv
// wfg_mem_arbiter: shares two single-port SRAM banks between a
// Wishbone slave port and a one-read-per-cycle stream port.
//
// Ports:
//   io_wbs_*          Wishbone slave (clock, sync active-low reset,
//                     adr/datwr/sel/we/stb/cyc in, ack/datrd out)
//   req_valid/addr    stream read request, req_ready = granted now
//   rsp_valid/data    stream read response, one cycle after grant
//   *_mem0/*_mem1     SRAM bank 0/1 control, data in/out
module wfg_mem_arbiter #(
  parameter int MAX_STARVE = 4
) (
  input  logic        io_wbs_clk,
  input  logic        io_wbs_rst_n,
  input  logic [31:0] io_wbs_adr,
  input  logic [31:0] io_wbs_datwr,
  input  logic [3:0]  io_wbs_sel,
  input  logic        io_wbs_we,
  input  logic        io_wbs_stb,
  input  logic        io_wbs_cyc,
  output logic        io_wbs_ack,
  output logic [31:0] io_wbs_datrd,
  input  logic        req_valid,
  input  logic [9:0]  req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        csb_mem0,
  output logic        csb_mem1,
  output logic        web_mem0,
  output logic        web_mem1,
  output logic [3:0]  wmask_mem0,
  output logic [3:0]  wmask_mem1,
  output logic [8:0]  addr_mem0,
  output logic [8:0]  addr_mem1,
  output logic [31:0] din_mem0,
  output logic [31:0] din_mem1,
  input  logic [31:0] dout_mem0,
  input  logic [31:0] dout_mem1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WB_RD  = 2'd1;
  localparam logic [1:0] WB_ACK = 2'd2;

  localparam int SW =
    (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

  logic [1:0]    r_state;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_datrd;
  logic          r_rsp_valid;
  logic          r_rsp_bank;
  logic          r_wb_bank;

  logic          w_ack;
  logic          w_wb_pend;
  logic          w_gnt_wb;
  logic          w_gnt_st;
  logic          w_use_wb;
  logic          w_bank;
  logic          w_wr;
  logic          w_any;
  logic [8:0]    w_addr;
  logic          w_unused;

  assign w_unused = ^{io_wbs_adr[31:12], io_wbs_adr[1:0]};

  assign w_ack = (r_state == WB_ACK);

  // Reset gates both requesters so nothing is granted in reset.
  assign w_wb_pend = io_wbs_rst_n & io_wbs_cyc & io_wbs_stb
                   & ~w_ack & (r_state == IDLE);

  assign w_gnt_wb = w_wb_pend
                  & (~req_valid | (r_starve == STARVE_MAX));
  assign w_gnt_st = io_wbs_rst_n & req_valid & ~w_gnt_wb;

  // With no grant, the side addr/din follow whichever requester
  // is active so the idle SRAM pins stay quiet.
  assign w_use_wb = w_gnt_wb
                  | (~w_gnt_st & io_wbs_cyc & io_wbs_stb);

  assign w_bank = w_use_wb ? io_wbs_adr[11] : req_addr[9];
  assign w_addr = w_use_wb ? io_wbs_adr[10:2] : req_addr[8:0];
  assign w_wr   = w_gnt_wb & io_wbs_we;
  assign w_any  = w_gnt_wb | w_gnt_st;

  assign csb_mem0   = ~(w_any & ~w_bank);
  assign csb_mem1   = ~(w_any & w_bank);
  assign web_mem0   = ~(w_wr & ~w_bank);
  assign web_mem1   = ~(w_wr & w_bank);
  assign wmask_mem0 = (w_wr & ~w_bank) ? io_wbs_sel : 4'b0000;
  assign wmask_mem1 = (w_wr & w_bank) ? io_wbs_sel : 4'b0000;
  assign addr_mem0  = w_addr;
  assign addr_mem1  = w_addr;
  assign din_mem0   = io_wbs_datwr;
  assign din_mem1   = io_wbs_datwr;

  assign req_ready    = w_gnt_st;
  assign io_wbs_ack   = w_ack;
  assign io_wbs_datrd = r_datrd;
  assign rsp_valid    = r_rsp_valid;

  // SRAM dout is live in the cycle after the access, so the
  // response is muxed straight from the bank chosen at grant.
  assign rsp_data = !r_rsp_valid ? 32'd0 :
                    r_rsp_bank ? dout_mem1 : dout_mem0;

  always_ff @(posedge io_wbs_clk) begin
    if (!io_wbs_rst_n) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_datrd     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_bank  <= 1'b0;
      r_wb_bank   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt_st;
      if (w_gnt_st) r_rsp_bank <= req_addr[9];
      if (w_gnt_wb) r_wb_bank <= io_wbs_adr[11];

      if (w_gnt_wb || !w_wb_pend)
        r_starve <= '0;
      else if (w_gnt_st && r_starve != STARVE_MAX)
        r_starve <= r_starve + 1'b1;

      unique case (r_state)
        IDLE: begin
          if (w_gnt_wb)
            r_state <= io_wbs_we ? WB_ACK : WB_RD;
        end
        WB_RD: begin
          // Master gave up: drop the read without an ack.
          if (!io_wbs_cyc) begin
            r_state <= IDLE;
          end else begin
            r_datrd <= r_wb_bank ? dout_mem1 : dout_mem0;
            r_state <= WB_ACK;
          end
        end
        WB_ACK:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// tb_wfg_mem_arbiter: random + directed scoreboard bench for
// wfg_mem_arbiter with a behavioural SRAM pair and shadow memory.
module tb_wfg_mem_arbiter;

  localparam int MAX_STARVE = 4;

  typedef struct packed {
    logic        rd;
    logic [31:0] d;
  } wb_ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] datwr;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic [31:0] datrd;
  logic        req_valid;
  logic [9:0]  req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        csb0, csb1, web0, web1;
  logic [3:0]  wm0, wm1;
  logic [8:0]  a0, a1;
  logic [31:0] di0, di1, do0, do1;

  always #5 clk = ~clk;

  wfg_mem_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
    .io_wbs_clk   (clk),
    .io_wbs_rst_n (rst_n),
    .io_wbs_adr   (adr),
    .io_wbs_datwr (datwr),
    .io_wbs_sel   (sel),
    .io_wbs_we    (we),
    .io_wbs_stb   (stb),
    .io_wbs_cyc   (cyc),
    .io_wbs_ack   (ack),
    .io_wbs_datrd (datrd),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .csb_mem0     (csb0),
    .csb_mem1     (csb1),
    .web_mem0     (web0),
    .web_mem1     (web1),
    .wmask_mem0   (wm0),
    .wmask_mem1   (wm1),
    .addr_mem0    (a0),
    .addr_mem1    (a1),
    .din_mem0     (di0),
    .din_mem1     (di1),
    .dout_mem0    (do0),
    .dout_mem1    (do1)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 32'h0001_9E37);
  endfunction

  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  bit          inited;

  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= init_val(i);
        mem1[i] <= init_val(512 + i);
      end
      inited <= 1'b1;
    end else begin
      if (!csb0) begin
        if (!web0) begin
          for (int b = 0; b < 4; b++)
            if (wm0[b]) mem0[a0][b*8 +: 8] <= di0[b*8 +: 8];
        end else begin
          do0 <= mem0[a0];
        end
      end
      if (!csb1) begin
        if (!web1) begin
          for (int b = 0; b < 4; b++)
            if (wm1[b]) mem1[a1][b*8 +: 8] <= di1[b*8 +: 8];
        end else begin
          do1 <= mem1[a1];
        end
      end
    end
  end

  logic [31:0] shadow [1024];
  wb_ent_t     wb_q [$];
  logic [31:0] st_q [$];
  int          wb_issue;
  int          wb_gnt;
  int          st_mode;
  int          errors;
  int          checks;

  logic        sn_csb0, sn_csb1, sn_web0, sn_web1;
  logic [3:0]  sn_m0, sn_m1;
  logic [8:0]  sn_a0, sn_a1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_stream();
    int seq;
    seq = 0;
    forever begin
      @(posedge clk);
      #1;
      case (st_mode)
        1: begin
          req_valid = 1'b1;
          req_addr  = 10'($urandom);
        end
        2: begin
          req_valid = 1'($urandom_range(0, 1));
          req_addr  = 10'($urandom);
        end
        3: begin
          req_valid = (seq < 8);
          req_addr  = 10'(seq);
          if (seq < 8) seq++;
        end
        default: req_valid = 1'b0;
      endcase
      if (st_mode != 3) seq = 0;
    end
  endtask

  // Reference: stream wins unless a waiting Wishbone request has
  // already watched MAX_STARVE stream grants go by.
  task automatic monitor();
    logic    exp_rdy;
    logic    last_gnt;
    int      run;
    logic    wait_wb;
    wb_ent_t w;
    logic [31:0] e;
    last_gnt = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n)
        chk("rst_sram_idle",
            32'({csb0, csb1, web0, web1}), 32'hF);
      chk("one_bank", 32'(csb0 | csb1), 32'd1);
      wait_wb = (wb_issue != wb_gnt);
      exp_rdy = rst_n && req_valid
              && !(wait_wb && run == MAX_STARVE);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(last_gnt));
      if (last_gnt && st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("rsp_data", rsp_data, e);
      end
      if (exp_rdy) st_q.push_back(shadow[req_addr]);
      last_gnt = exp_rdy;
      if (rst_n && wait_wb) begin
        if (exp_rdy) begin
          run++;
        end else begin
          wb_gnt++;
          run = 0;
        end
      end else begin
        run = 0;
      end
      if (ack) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected_ack", 32'(ack), 32'd0);
        end else begin
          w = wb_q.pop_front();
          if (w.rd) chk("wb_datrd", datrd, w.d);
        end
      end
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a,
                         input logic        w,
                         input logic [31:0] d,
                         input logic [3:0]  s,
                         output int         lat,
                         output int         nst);
    wb_ent_t ent;
    int      wi;
    wi = int'(a[11:2]);
    @(posedge clk);
    #1;
    adr   = a;
    we    = w;
    datwr = d;
    sel   = s;
    cyc   = 1'b1;
    stb   = 1'b1;
    wb_issue++;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) shadow[wi][b*8 +: 8] = d[b*8 +: 8];
      ent.rd = 1'b0;
      ent.d  = 32'd0;
    end else begin
      ent.rd = 1'b1;
      ent.d  = shadow[wi];
    end
    wb_q.push_back(ent);
    lat = -1;
    nst = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (nst < 0 && !req_ready) begin
        nst = n;
        sn_csb0 = csb0;
        sn_csb1 = csb1;
        sn_web0 = web0;
        sn_web1 = web1;
        sn_m0   = wm0;
        sn_m1   = wm1;
        sn_a0   = a0;
        sn_a1   = a1;
      end
      if (ack) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  initial begin
    int lat;
    int nst;
    int nr;
    int nv;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    rst_n     = 1'b0;
    adr       = 32'd0;
    datwr     = 32'd0;
    sel       = 4'd0;
    we        = 1'b0;
    stb       = 1'b0;
    cyc       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 10'd0;
    st_mode   = 1;
    wb_issue  = 0;
    wb_gnt    = 0;
    errors    = 0;
    checks    = 0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

    fork
      drive_stream();
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset held with a stream request active.
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_datrd", datrd, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    st_mode = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write then read word 1 of bank 0.
    wb_xfer(32'h004, 1'b1, 32'hDEADBEEF, 4'hF, lat, nst);
    chk("s1_wr_lat", lat, 32'd1);
    chk("s1_csb0", 32'(sn_csb0), 32'd0);
    chk("s1_web0", 32'(sn_web0), 32'd0);
    chk("s1_addr0", 32'(sn_a0), 32'd1);
    chk("s1_wmask0", 32'(sn_m0), 32'hF);
    chk("s1_csb1", 32'(sn_csb1), 32'd1);
    wb_xfer(32'h004, 1'b0, 32'd0, 4'hF, lat, nst);
    chk("s1_rd_lat", lat, 32'd2);
    chk("s1_datrd", datrd, 32'hDEADBEEF);

    // Partial write to bank 1 word 0.
    wb_xfer(32'h800, 1'b1, 32'h1234_5678, 4'b0011, lat, nst);
    chk("s2_wr_lat", lat, 32'd1);
    chk("s2_csb1", 32'(sn_csb1), 32'd0);
    chk("s2_web1", 32'(sn_web1), 32'd0);
    chk("s2_wmask1", 32'(sn_m1), 32'h3);
    chk("s2_addr1", 32'(sn_a1), 32'd0);
    chk("s2_csb0", 32'(sn_csb0), 32'd1);

    // Eight back-to-back stream reads, addresses 0..7.
    @(negedge clk);
    st_mode = 3;
    nr = 0;
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (req_ready) nr++;
      if (rsp_valid) nv++;
    end
    st_mode = 0;
    chk("s3_grants", nr, 32'd8);
    chk("s3_rsps", nv, 32'd8);

    // Wishbone read under a saturating stream.
    @(negedge clk);
    st_mode = 1;
    wb_xfer(32'h004, 1'b0, 32'd0, 4'hF, lat, nst);
    chk("s4_stream_before_wb", nst, 32'(MAX_STARVE));
    chk("s4_rd_lat", lat, 32'(MAX_STARVE + 2));
    @(negedge clk);
    st_mode = 0;
    repeat (3) @(negedge clk);

    // Abort a read by dropping cyc in WB_RD.
    @(posedge clk);
    #1;
    adr = 32'h008;
    we  = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    wb_issue++;
    @(posedge clk);
    #1;
    cyc = 1'b0;
    stb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("s5_abort_ack", 32'(ack), 32'd0);
    end
    chk("s5_abort_datrd", datrd, 32'hDEADBEEF);
    wb_xfer(32'h008, 1'b0, 32'd0, 4'hF, lat, nst);
    chk("s5_rd_lat", lat, 32'd2);

    // Reset between a read grant and its ack.
    @(posedge clk);
    #1;
    adr = 32'h004;
    we  = 1'b0;
    cyc = 1'b1;
    stb = 1'b1;
    wb_issue++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc   = 1'b0;
    stb   = 1'b0;
    @(negedge clk);
    chk("s6_ack_in_rst", 32'(ack), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("s6_ack", 32'(ack), 32'd0);
      chk("s6_datrd", datrd, 32'd0);
      chk("s6_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // Random Wishbone traffic, stream idle.
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      wb_xfer(a, w, d, 4'($urandom), lat, nst);
      chk(w ? "r1_wr_lat" : "r1_rd_lat",
          lat, w ? 32'd1 : 32'd2);
    end

    // Random Wishbone reads against random stream traffic.
    @(negedge clk);
    st_mode = 2;
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      wb_xfer($urandom, 1'b0, 32'd0, 4'hF, lat, nst);
      chk("r2_rd_lat",
          32'(lat >= 2 && lat <= MAX_STARVE + 2), 32'd1);
    end
    @(negedge clk);
    st_mode = 0;
    repeat (4) @(negedge clk);
    chk("end_wb_q", 32'(wb_q.size()), 32'd0);
    chk("end_st_q", 32'(st_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
